// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V register-file types and helpers
package riscv_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xlen_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t a);
        reg_onehot    = '0;
        reg_onehot[a] = 1'b1;
    endfunction

endpackage

// File: rtl/riscv_scoreboard.sv
// rtl/riscv_scoreboard.sv - per-register busy bits with an in-flight destination counter
module riscv_scoreboard
    import riscv_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_set_en,
    input  reg_addr_t           i_set_addr,
    input  logic                i_clr_en,
    input  reg_addr_t           i_clr_addr,
    input  logic                i_fl_en,
    input  reg_addr_t           i_fl_addr,
    output logic [NUM_REGS-1:0] o_busy,
    output logic                o_full
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    logic [NUM_REGS-1:0] r_sb;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_set;
    logic                w_set_new;
    logic                w_clr_wb;
    logic                w_clr_fl;
    logic                w_dec_wb;
    logic                w_dec_fl;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic [CNT_W-1:0]    w_cnt_next;

    always_comb begin
        w_set     = i_set_en && (i_set_addr != '0);
        w_set_new = w_set && !r_sb[i_set_addr];
        w_clr_wb  = i_clr_en && (i_clr_addr != '0) && r_sb[i_clr_addr];
        // A flush and a writeback to the same register must only release one slot.
        w_clr_fl  = i_fl_en && (i_fl_addr != '0) && r_sb[i_fl_addr]
                    && !(w_clr_wb && (i_fl_addr == i_clr_addr));
        // When a new writer claims the register being released, set wins and the count holds.
        w_dec_wb  = w_clr_wb && !(w_set && (i_set_addr == i_clr_addr));
        w_dec_fl  = w_clr_fl && !(w_set && (i_set_addr == i_fl_addr));

        w_set_mask = w_set ? reg_onehot(i_set_addr) : '0;
        w_clr_mask = '0;
        if (w_clr_wb) w_clr_mask = w_clr_mask | reg_onehot(i_clr_addr);
        if (w_clr_fl) w_clr_mask = w_clr_mask | reg_onehot(i_fl_addr);

        w_cnt_next = r_cnt + CNT_W'(w_set_new) - CNT_W'(w_dec_wb) - CNT_W'(w_dec_fl);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sb  <= '0;
            r_cnt <= '0;
        end else begin
            r_sb  <= (r_sb & ~w_clr_mask) | w_set_mask;
            r_cnt <= w_cnt_next;
        end
    end

    assign o_busy = r_sb & ~NUM_REGS'(1);
    assign o_full = (r_cnt == CNT_W'(MAX_INFLIGHT));

    a_cnt_max: assert property (@(posedge clk) disable iff (!reset)
        r_cnt <= CNT_W'(MAX_INFLIGHT));
    a_cnt_underflow: assert property (@(posedge clk) disable iff (!reset)
        ({1'b0, r_cnt} + (CNT_W+1)'(w_set_new)) >= ((CNT_W+1)'(w_dec_wb) + (CNT_W+1)'(w_dec_fl)));

endmodule

// File: rtl/riscv_operand_fetch.sv
// rtl/riscv_operand_fetch.sv - hazard-checked operand fetch into a single execute register
// Optional writeback bypass enabled by defining RISCV_OPF_BYPASS_EN.
module riscv_operand_fetch
    import riscv_pkg::*;
#(
    parameter int CTL_W        = 16,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_valid_i,
    output logic             dec_ready_o,
    input  reg_addr_t        dec_rs1_i,
    input  reg_addr_t        dec_rs2_i,
    input  reg_addr_t        dec_rd_i,
    input  logic             dec_rd_wr_i,
    input  logic [CTL_W-1:0] dec_ctl_i,
    output reg_addr_t        rf_rd_p0_o,
    output reg_addr_t        rf_rd_p1_o,
    input  xlen_t            rf_rd_p0_data_i,
    input  xlen_t            rf_rd_p1_data_i,
    input  logic             wb_en_i,
    input  reg_addr_t        wb_addr_i,
    input  xlen_t            wb_data_i,
    input  logic             flush_i,
    output logic             ex_valid_o,
    input  logic             ex_ready_i,
    output xlen_t            ex_rs1_data_o,
    output xlen_t            ex_rs2_data_o,
    output reg_addr_t        ex_rd_o,
    output logic             ex_rd_wr_o,
    output logic [CTL_W-1:0] ex_ctl_o
);

`ifdef RISCV_OPF_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    logic             r_ex_valid;
    xlen_t            r_ex_rs1;
    xlen_t            r_ex_rs2;
    reg_addr_t        r_ex_rd;
    logic             r_ex_rd_wr;
    logic [CTL_W-1:0] r_ex_ctl;

    logic [NUM_REGS-1:0] w_busy;
    logic                w_full;
    logic                w_byp_rs1;
    logic                w_byp_rs2;
    logic                w_byp_rd;
    logic                w_busy_rs1;
    logic                w_busy_rs2;
    logic                w_busy_rd;
    logic                w_hazard;
    logic                w_accept;
    xlen_t               w_op1;
    xlen_t               w_op2;

    assign rf_rd_p0_o = dec_rs1_i;
    assign rf_rd_p1_o = dec_rs2_i;

    always_comb begin
        w_byp_rs1 = BYPASS && wb_en_i && (wb_addr_i == dec_rs1_i) && (dec_rs1_i != '0);
        w_byp_rs2 = BYPASS && wb_en_i && (wb_addr_i == dec_rs2_i) && (dec_rs2_i != '0);
        w_byp_rd  = BYPASS && wb_en_i && (wb_addr_i == dec_rd_i)  && (dec_rd_i  != '0);

        w_busy_rs1 = w_busy[dec_rs1_i] && !w_byp_rs1;
        w_busy_rs2 = w_busy[dec_rs2_i] && !w_byp_rs2;
        w_busy_rd  = w_busy[dec_rd_i]  && !w_byp_rd;

        w_hazard = w_busy_rs1 || w_busy_rs2
                   || (dec_rd_wr_i && w_busy_rd)
                   || (dec_rd_wr_i && (dec_rd_i != '0) && w_full);

        dec_ready_o = (!r_ex_valid || ex_ready_i) && !w_hazard && !flush_i;
        w_accept    = dec_valid_i && dec_ready_o;

        // The regfile write lands at the edge, so a same-cycle writeback must come from the bus.
        w_op1 = rf_rd_p0_data_i;
        if (dec_rs1_i == '0)  w_op1 = '0;
        else if (w_byp_rs1)   w_op1 = wb_data_i;
        w_op2 = rf_rd_p1_data_i;
        if (dec_rs2_i == '0)  w_op2 = '0;
        else if (w_byp_rs2)   w_op2 = wb_data_i;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex_valid <= 1'b0;
            r_ex_rs1   <= '0;
            r_ex_rs2   <= '0;
            r_ex_rd    <= '0;
            r_ex_rd_wr <= 1'b0;
            r_ex_ctl   <= '0;
        end else if (flush_i) begin
            r_ex_valid <= 1'b0;
        end else if (w_accept) begin
            r_ex_valid <= 1'b1;
            r_ex_rs1   <= w_op1;
            r_ex_rs2   <= w_op2;
            r_ex_rd    <= dec_rd_i;
            r_ex_rd_wr <= dec_rd_wr_i;
            r_ex_ctl   <= dec_ctl_i;
        end else if (ex_ready_i) begin
            r_ex_valid <= 1'b0;
        end
    end

    riscv_scoreboard #(
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .i_set_en   (w_accept && dec_rd_wr_i),
        .i_set_addr (dec_rd_i),
        .i_clr_en   (wb_en_i),
        .i_clr_addr (wb_addr_i),
        .i_fl_en    (flush_i && r_ex_valid && r_ex_rd_wr),
        .i_fl_addr  (r_ex_rd),
        .o_busy     (w_busy),
        .o_full     (w_full)
    );

    assign ex_valid_o    = r_ex_valid;
    assign ex_rs1_data_o = r_ex_rs1;
    assign ex_rs2_data_o = r_ex_rs2;
    assign ex_rd_o       = r_ex_rd;
    assign ex_rd_wr_o    = r_ex_rd_wr;
    assign ex_ctl_o      = r_ex_ctl;

endmodule

// File: tb/tb_riscv_operand_fetch.sv
// tb/tb_riscv_operand_fetch.sv - randomized and directed checks of riscv_operand_fetch against a queue model
module tb_riscv_operand_fetch;
    import riscv_pkg::*;

    localparam int CTL_W = 16;
    localparam int MAXI  = 4;
`ifdef RISCV_OPF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             dec_valid_i;
    logic             dec_ready_o;
    reg_addr_t        dec_rs1_i, dec_rs2_i, dec_rd_i;
    logic             dec_rd_wr_i;
    logic [CTL_W-1:0] dec_ctl_i;
    reg_addr_t        rf_rd_p0_o, rf_rd_p1_o;
    xlen_t            rf_rd_p0_data_i, rf_rd_p1_data_i;
    logic             wb_en_i;
    reg_addr_t        wb_addr_i;
    xlen_t            wb_data_i;
    logic             flush_i;
    logic             ex_valid_o;
    logic             ex_ready_i;
    xlen_t            ex_rs1_data_o, ex_rs2_data_o;
    reg_addr_t        ex_rd_o;
    logic             ex_rd_wr_o;
    logic [CTL_W-1:0] ex_ctl_o;

    riscv_operand_fetch #(.CTL_W(CTL_W), .MAX_INFLIGHT(MAXI)) dut (
        .clk(clk), .reset(reset),
        .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
        .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i), .dec_rd_i(dec_rd_i),
        .dec_rd_wr_i(dec_rd_wr_i), .dec_ctl_i(dec_ctl_i),
        .rf_rd_p0_o(rf_rd_p0_o), .rf_rd_p1_o(rf_rd_p1_o),
        .rf_rd_p0_data_i(rf_rd_p0_data_i), .rf_rd_p1_data_i(rf_rd_p1_data_i),
        .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .flush_i(flush_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
        .ex_rd_o(ex_rd_o), .ex_rd_wr_o(ex_rd_wr_o), .ex_ctl_o(ex_ctl_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment regfile: written at the clock edge, read asynchronously.
    xlen_t rf_mem [NUM_REGS];
    assign rf_rd_p0_data_i = rf_mem[rf_rd_p0_o];
    assign rf_rd_p1_data_i = rf_mem[rf_rd_p1_o];

    int n_chk = 0;
    int n_bad = 0;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Model: registers with an outstanding writer, and the subset whose writer has left for execute.
    int               inflight[$];
    int               done_q[$];
    bit               m_v;
    xlen_t            m_op1, m_op2;
    int               m_rd;
    bit               m_rdwr;
    logic [CTL_W-1:0] m_ctl;
    bit               seen_ready;

    function automatic bit in_flight(input int r);
        foreach (inflight[i]) if (inflight[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drop(input int r);
        for (int i = inflight.size() - 1; i >= 0; i--) if (inflight[i] == r) inflight.delete(i);
        for (int i = done_q.size() - 1; i >= 0; i--) if (done_q[i] == r) done_q.delete(i);
    endtask

    function automatic bit busy_now(input int r);
        return (r != 0) && in_flight(r) && !(BYP && wb_en_i && (int'(wb_addr_i) == r));
    endfunction

    function automatic bit model_ready();
        bit hz;
        hz = busy_now(dec_rs1_i) || busy_now(dec_rs2_i)
             || (dec_rd_wr_i && busy_now(dec_rd_i))
             || (dec_rd_wr_i && (dec_rd_i != 0) && (inflight.size() == MAXI));
        return (!m_v || ex_ready_i) && !hz && !flush_i;
    endfunction

    function automatic xlen_t model_operand(input int rs);
        if (rs == 0) return '0;
        if (BYP && wb_en_i && (int'(wb_addr_i) == rs)) return wb_data_i;
        return rf_mem[rs];
    endfunction

    task automatic reset_model();
        inflight.delete();
        done_q.delete();
        m_v = 1'b0; m_op1 = '0; m_op2 = '0; m_rd = 0; m_rdwr = 1'b0; m_ctl = '0;
    endtask

    // One clock: check DUT against model at negedge, advance model, let the edge happen.
    task automatic cycle();
        bit    acc;
        xlen_t op1, op2;
        bit    pend_we;
        int    pend_a;
        xlen_t pend_d;
        @(negedge clk);
        seen_ready = dec_ready_o;
        expect_eq("dec_ready", dec_ready_o, model_ready());
        expect_eq("ex_valid", ex_valid_o, m_v);
        expect_eq("inflight_cnt", dut.u_sb.r_cnt, inflight.size());
        expect_eq("rf_addr0", rf_rd_p0_o, dec_rs1_i);
        if (m_v) begin
            expect_eq("ex_rs1", ex_rs1_data_o, m_op1);
            expect_eq("ex_rs2", ex_rs2_data_o, m_op2);
            expect_eq("ex_rd", ex_rd_o, m_rd);
            expect_eq("ex_rd_wr", ex_rd_wr_o, m_rdwr);
            expect_eq("ex_ctl", ex_ctl_o, m_ctl);
        end
        acc = dec_valid_i && model_ready();
        op1 = model_operand(dec_rs1_i);
        op2 = model_operand(dec_rs2_i);
        if (flush_i) begin
            if (m_v && m_rdwr && m_rd != 0) drop(m_rd);
            m_v = 1'b0;
        end else begin
            if (m_v && ex_ready_i) begin
                if (m_rdwr && m_rd != 0) done_q.push_back(m_rd);
                m_v = 1'b0;
            end
            if (acc) begin
                m_v = 1'b1; m_op1 = op1; m_op2 = op2;
                m_rd = dec_rd_i; m_rdwr = dec_rd_wr_i; m_ctl = dec_ctl_i;
            end
        end
        if (wb_en_i && wb_addr_i != 0) drop(wb_addr_i);
        if (acc && dec_rd_wr_i && dec_rd_i != 0) inflight.push_back(dec_rd_i);
        pend_we = wb_en_i && (wb_addr_i != 0);
        pend_a  = wb_addr_i;
        pend_d  = wb_data_i;
        @(posedge clk);
        #1;
        if (pend_we) rf_mem[pend_a] = pend_d;
    endtask

    task automatic drv(input bit v, input int rs1, input int rs2, input int rd, input bit rdwr,
                       input bit exr, input bit fl, input bit wbe, input int wba, input xlen_t wbd);
        dec_valid_i = v; dec_rs1_i = rs1[4:0]; dec_rs2_i = rs2[4:0]; dec_rd_i = rd[4:0];
        dec_rd_wr_i = rdwr; dec_ctl_i = CTL_W'($urandom);
        ex_ready_i = exr; flush_i = fl;
        wb_en_i = wbe; wb_addr_i = wba[4:0]; wb_data_i = wbd;
    endtask

    task automatic drv_rand();
        int r;
        drv($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            1'b0, 0, '0);
        if (done_q.size() > 0 && $urandom_range(0, 2) == 0) begin
            wb_en_i = 1'b1;
            wb_addr_i = done_q[$urandom_range(0, done_q.size() - 1)][4:0];
            wb_data_i = $urandom;
        end else if ($urandom_range(0, 7) == 0) begin
            r = $urandom_range(0, 31);
            if (!in_flight(r)) begin
                wb_en_i = 1'b1; wb_addr_i = r[4:0]; wb_data_i = $urandom;
            end
        end
    endtask

    logic [CTL_W-1:0] held_ctl;
    logic [CTL_W-1:0] new_ctl;

    initial begin
        for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = $urandom;
        rf_mem[0] = 32'hFFFF_FFFF;
        reset = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        expect_eq("rst_ex_valid", ex_valid_o, 1'b0);
        expect_eq("rst_ex_rs1", ex_rs1_data_o, 32'h0);
        expect_eq("rst_ex_ctl", ex_ctl_o, 32'h0);
        expect_eq("rst_cnt", dut.u_sb.r_cnt, 32'h0);
        reset = 1'b1;

        // Dependent read on x5 stalls until the writeback.
        drv(1, 0, 0, 5, 1, 1, 0, 0, 0, '0);            cycle();
        drv(1, 5, 0, 0, 0, 1, 0, 0, 0, '0);            cycle();
        expect_eq("t2_stall", seen_ready, 1'b0);
        drv(1, 5, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF);  cycle();
        expect_eq("t2_wb_cycle_ready", seen_ready, BYP);
        drv(1, 5, 0, 0, 0, 0, 0, 0, 0, '0);            cycle();
        expect_eq("t2_ex_valid", ex_valid_o, 1'b1);
        expect_eq("t2_op1", ex_rs1_data_o, 32'hDEADBEEF);
        drv(0, 0, 0, 0, 0, 1, 0, 0, 0, '0);            cycle();

        // x0 reads as zero and is never marked busy.
        drv(1, 0, 0, 0, 1, 1, 0, 0, 0, '0);            cycle();
        expect_eq("t3_op1", ex_rs1_data_o, 32'h0);
        expect_eq("t3_op2", ex_rs2_data_o, 32'h0);
        expect_eq("t3_sb", dut.u_sb.r_sb, 32'h0);

        // Four outstanding writers fill the scoreboard; a fifth waits for a writeback.
        for (int r = 1; r <= 4; r++) begin
            drv(1, 0, 0, r, 1, 1, 0, 0, 0, '0);        cycle();
        end
        drv(1, 0, 0, 6, 1, 1, 0, 0, 0, '0);            cycle();
        expect_eq("t4_full_stall", seen_ready, 1'b0);
        drv(1, 0, 0, 6, 1, 1, 0, 1, 2, 32'h1234_5678); cycle();
        expect_eq("t4_wb_cycle_stall", seen_ready, 1'b0);
        drv(1, 0, 0, 6, 1, 1, 0, 0, 0, '0);            cycle();
        expect_eq("t4_accept_after_wb", seen_ready, 1'b1);
        foreach (inflight[i]) $display("info: draining x%0d", inflight[i]);
        while (inflight.size() > 0) begin
            drv(0, 0, 0, 0, 0, 1, 0, 1, inflight[0], $urandom); cycle();
        end

        // Backpressure holds the output register; release loads the next entry at once.
        drv(1, 1, 2, 0, 0, 1, 0, 0, 0, '0);            cycle();
        held_ctl = ex_ctl_o;
        for (int i = 0; i < 3; i++) begin
            drv(1, 3, 4, 0, 0, 0, 0, 0, 0, '0);        cycle();
            expect_eq("t5_hold_ready", seen_ready, 1'b0);
            expect_eq("t5_hold_ctl", ex_ctl_o, held_ctl);
        end
        drv(1, 3, 4, 0, 0, 1, 0, 0, 0, '0);
        new_ctl = dec_ctl_i;                           cycle();
        expect_eq("t5_release_ready", seen_ready, 1'b1);
        expect_eq("t5_new_ctl", ex_ctl_o, new_ctl);

        // Flushing a held writer frees its destination.
        drv(1, 0, 0, 7, 1, 1, 0, 0, 0, '0);            cycle();
        drv(0, 0, 0, 0, 0, 0, 1, 0, 0, '0);            cycle();
        expect_eq("t6_ex_valid", ex_valid_o, 1'b0);
        expect_eq("t6_sb7", dut.u_sb.r_sb[7], 1'b0);
        drv(1, 7, 0, 0, 0, 1, 0, 0, 0, '0);            cycle();
        expect_eq("t6_no_stall", seen_ready, 1'b1);

        for (int n = 0; n < 3000; n++) begin
            drv_rand();
            cycle();
        end

        // Asynchronous reset while an entry is held.
        for (int n = 0; n < 6 && !m_v; n++) begin
            drv(1, 0, 0, 0, 0, 0, 0, 0, 0, '0);        cycle();
        end
        expect_eq("t1_pre_valid", ex_valid_o, 1'b1);
        reset = 1'b0;
        #2;
        expect_eq("t1_ex_valid", ex_valid_o, 1'b0);
        expect_eq("t1_cnt", dut.u_sb.r_cnt, 32'h0);
        expect_eq("t1_sb", dut.u_sb.r_sb, 32'h0);
        expect_eq("t1_ex_rs1", ex_rs1_data_o, 32'h0);
        reset_model();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int n = 0; n < 200; n++) begin
            drv_rand();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
